seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised serial pattern detector, the successor to the team's fixed 1011 Mealy detector. It has a runtime-loadable pattern of PAT_LEN bits, overlapping or non-overlapping mode, input qualification via x_valid, and a saturating match counter. It sits on the serial bit stream ahead of the framing logic and flags each completed pattern in the same cycle as its last bit (Mealy).

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..32.
CNT_W, 8, width of the saturating match counter.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
x  input  1  serial data bit.
x_valid  input  1  x is sampled only when high.
pat_load  input  1  one-cycle strobe; latch pat_in and clear history.
pat_in  input  PAT_LEN  new pattern; bit PAT_LEN-1 is the first bit received.
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
cnt_clr  input  1  synchronous clear of match_count.
y  output  1  match pulse (Mealy, combinational from registered state and x/x_valid).
match_count  output  CNT_W  number of matches, saturating.
armed  output  1  pattern loaded since reset.

Behaviour:
- Reset (async, active-high) values: pattern=0, hist=0, fill=0, armed=0, match_count=0. y=0 while reset is high.
- State machine is 2-state: UNARMED -> ARMED on pat_load. pat_load while ARMED stays ARMED with the new pattern. y is forced to 0 in UNARMED.
- hist: PAT_LEN-1 bit register. On an accepted bit (x_valid=1, no pat_load), hist <= {hist[PAT_LEN-3:0], x}, with the newest bit in the LSB.
- fill: counts accepted bits. It is $clog2(PAT_LEN) bits wide and saturates at PAT_LEN-1.
- Match condition: armed && x_valid && !pat_load && fill==PAT_LEN-1 && {hist, x}==pattern. y equals the match condition, with zero latency.
- On a match with overlap_en=1: hist shifts normally and fill is kept, so a suffix of the match can start the next match.
- On a match with overlap_en=0: fill <= 0 and hist <= 0. The next match needs PAT_LEN fresh bits.
- x_valid=0: hist, fill and y are held (y=0). Gaps of any length are transparent.
- pat_load: pattern <= pat_in, hist <= 0, fill <= 0. x in the same cycle is discarded and y=0. match_count is unaffected.
- match_count increments by 1 on each match cycle and saturates at 2^CNT_W-1 (no wrap).
- cnt_clr has priority over an increment in the same cycle: result is 0.
- Toggling overlap_en mid-stream takes effect on the next match. No flush.
- Reset mid-operation returns to UNARMED. The pattern must be reloaded.

Optional Feature:
Macro SEQDET_REG_OUT_EN.
- Defined: y is registered (Moore-style). It pulses one cycle after the matching bit, and its reset value is 0. match_count timing is unchanged.
- Undefined: y is combinational, as described under Behaviour.

Decomposition:
- Package seq_det_pkg: state enum typedef (ST_UNARMED, ST_ARMED), PAT_LEN min/max constants, and a function computing the fill width.
- Sub-module seq_sat_counter: parametrised CNT_W saturating counter with inc and clr inputs (clr wins). Instantiated once for match_count.

Test Plan:
1. Load 1011, overlap_en=1, stream 1,0,1,1,0,1,1 (x_valid=1) -> y=1 on bits 4 and 7, match_count=2.
2. Same stream with overlap_en=0 -> y=1 on bit 4 only, match_count=1. Then stream 1,0,1,1 -> y=1 on the 4th bit, count=2.
3. Pattern 1011, stream 1,0,1,1 with x_valid=0 gap cycles between each bit -> single y pulse coincident with the last valid 1. y=0 in all gap cycles.
4. CNT_W=2, pattern 11, overlap_en=1, six consecutive 1s -> 5 matches, match_count stops at 3. Then cnt_clr and a match in the same cycle -> 0.
5. Load 1011, send 1,0,1, then pat_load with 0110, then 1,1,0 -> no y (history cleared). Then 0,1,1,0 -> y on the last 0.
6. Assert reset after 1,0,1 -> all outputs 0 and armed=0. Stream 1011 without reload -> no y. With SEQDET_REG_OUT_EN defined, scenario 1 gives y one cycle late (bits 5 and 8).

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        ST_UNARMED = 1'b0,
        ST_ARMED   = 1'b1
    } seq_state_t;

    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 32;

    // Fill counter only has to reach PAT_LEN-1, so $clog2(PAT_LEN) bits suffice.
    function automatic int fill_width(input int pat_len);
        return (pat_len <= 2) ? 1 : $clog2(pat_len);
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control and match counter.
// Define SEQDET_REG_OUT_EN to register y (pulses one cycle after the matching bit).
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               overlap_en,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);

    localparam int FILL_W = fill_width(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_pat_len
        $error("seq_detector_param: PAT_LEN out of range");
    end

    seq_state_t         state;
    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-2:0] hist;
    logic [FILL_W-1:0]  fill;
    logic [PAT_LEN-1:0] window;
    logic               accept;
    logic               match;

    // Window is the stored history with the current bit appended as the newest.
    assign window = {hist, x};
    assign accept = x_valid && !pat_load;
    assign match  = (state == ST_ARMED) && accept && (fill == FILL_MAX) && (window == pattern);
    assign armed  = (state == ST_ARMED);

`ifdef SEQDET_REG_OUT_EN
    logic y_q;
    assign y = y_q;
`else
    assign y = match;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_UNARMED;
            pattern <= '0;
            hist    <= '0;
            fill    <= '0;
`ifdef SEQDET_REG_OUT_EN
            y_q     <= 1'b0;
`endif
        end else begin
`ifdef SEQDET_REG_OUT_EN
            y_q <= match;
`endif
            if (pat_load) begin
                state   <= ST_ARMED;
                pattern <= pat_in;
                hist    <= '0;
                fill    <= '0;
            end else if (x_valid) begin
                if (match && !overlap_en) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= window[PAT_LEN-2:0];
                    if (fill != FILL_MAX) begin
                        fill <= fill + FILL_W'(1);
                    end
                end
            end
        end
    end

    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (cnt_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: two detector instances (PAT_LEN=4/CNT_W=8 and PAT_LEN=2/CNT_W=2)
// checked every cycle against a bit-history reference model, plus directed literal checks.
module tb_seq_detector_param;

`ifdef SEQDET_REG_OUT_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       x0 = 0, xv0 = 0, pl0 = 0, ov0 = 0, cc0 = 0;
    logic [3:0] pin0 = '0;
    logic       y0, arm0;
    logic [7:0] cnt0;

    logic       x1 = 0, xv1 = 0, pl1 = 0, ov1 = 0, cc1 = 0;
    logic [1:0] pin1 = '0;
    logic       y1, arm1;
    logic [1:0] cnt1;

    seq_detector_param #(.PAT_LEN(4), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .x(x0), .x_valid(xv0), .pat_load(pl0), .pat_in(pin0),
        .overlap_en(ov0), .cnt_clr(cc0), .y(y0), .match_count(cnt0), .armed(arm0)
    );

    seq_detector_param #(.PAT_LEN(2), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .x(x1), .x_valid(xv1), .pat_load(pl1), .pat_in(pin1),
        .overlap_en(ov1), .cnt_clr(cc1), .y(y1), .match_count(cnt1), .armed(arm1)
    );

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bits accepted since the last clear, newest in bit 0.
    int          m_len [2] = '{4, 2};
    int          m_max [2] = '{255, 3};
    logic [63:0] m_bits[2];
    int          m_n   [2];
    bit          m_arm [2];
    logic [31:0] m_pat [2];
    int          m_cnt [2];
    bit          m_yreg[2];

    function automatic bit mmatch(input int i, input bit b, input bit v, input bit pl);
        logic [63:0] w;
        logic [63:0] mask;
        w    = (m_bits[i] << 1) | 64'(b);
        mask = (64'd1 << m_len[i]) - 64'd1;
        return m_arm[i] && v && !pl && (m_n[i] >= m_len[i] - 1) && ((w & mask) == 64'(m_pat[i]));
    endfunction

    task automatic mupd(input int i, input bit b, input bit v, input bit pl,
                        input logic [31:0] pin, input bit ov, input bit cc);
        bit mt;
        mt = mmatch(i, b, v, pl);
        m_yreg[i] = mt;
        if (cc) m_cnt[i] = 0;
        else if (mt && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
        if (pl) begin
            m_arm[i]  = 1'b1;
            m_pat[i]  = pin;
            m_bits[i] = '0;
            m_n[i]    = 0;
        end else if (v) begin
            if (mt && !ov) begin
                m_bits[i] = '0;
                m_n[i]    = 0;
            end else begin
                m_bits[i] = (m_bits[i] << 1) | 64'(b);
                if (m_n[i] < 40) m_n[i] = m_n[i] + 1;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_bits[i] = '0; m_n[i] = 0; m_arm[i] = 0; m_pat[i] = '0; m_cnt[i] = 0; m_yreg[i] = 0;
            end
        end else begin
            mupd(0, x0, xv0, pl0, 32'(pin0), ov0, cc0);
            mupd(1, x1, xv1, pl1, 32'(pin1), ov1, cc1);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("y0", y0, REG_OUT ? m_yreg[0] : mmatch(0, x0, xv0, pl0));
        chk("y1", y1, REG_OUT ? m_yreg[1] : mmatch(1, x1, xv1, pl1));
        chk("count0", cnt0, m_cnt[0]);
        chk("count1", cnt1, m_cnt[1]);
        chk("armed0", arm0, m_arm[0]);
        chk("armed1", arm1, m_arm[1]);
    end

    bit pe0 = 0, pe1 = 0;

    task automatic send0(input bit b, input bit v, input bit pl, input logic [3:0] pin,
                         input bit cc, input bit e);
        @(posedge clk); #1;
        x0 = b; xv0 = v; pl0 = pl; pin0 = pin; cc0 = cc;
        xv1 = 0; pl1 = 0; cc1 = 0;
        @(negedge clk);
        chk("y0_lit", y0, REG_OUT ? pe0 : e);
        pe0 = e;
    endtask

    task automatic send1(input bit b, input bit v, input bit pl, input logic [1:0] pin,
                         input bit cc, input bit e);
        @(posedge clk); #1;
        x1 = b; xv1 = v; pl1 = pl; pin1 = pin; cc1 = cc;
        xv0 = 0; pl0 = 0; cc0 = 0;
        @(negedge clk);
        chk("y1_lit", y1, REG_OUT ? pe1 : e);
        pe1 = e;
    endtask

    task automatic bits0(input logic [15:0] seq, input logic [15:0] exp, input int n);
        logic [15:0] s, e;
        s = seq; e = exp;
        for (int k = n - 1; k >= 0; k--) send0(s[k], 1'b1, 1'b0, 4'h0, 1'b0, e[k]);
    endtask

    task automatic load0(input logic [3:0] p);  send0(1'b1, 1'b1, 1'b1, p, 1'b0, 1'b0); endtask
    task automatic idle0();                     send0(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0); endtask
    task automatic clr0();                      send0(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0); endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_armed0", arm0, 0);
        chk("reset_count0", cnt0, 0);
        chk("reset_y0", y0, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Overlapping detection of 1011 in 1011011
        ov0 = 1'b1;
        load0(4'b1011);
        bits0(16'b1011011, 16'b0001001, 7);
        idle0();
        chk("s1_count", cnt0, 2);

        // Non-overlapping: second 1011 shares a suffix and must not fire
        clr0();
        ov0 = 1'b0;
        load0(4'b1011);
        bits0(16'b1011011, 16'b0001000, 7);
        idle0();
        chk("s2_count_a", cnt0, 1);
        bits0(16'b1011, 16'b0001, 4);
        idle0();
        chk("s2_count_b", cnt0, 2);

        // Gaps between valid bits are transparent
        clr0();
        ov0 = 1'b1;
        load0(4'b1011);
        send0(1, 1, 0, 0, 0, 0); idle0();
        send0(0, 1, 0, 0, 0, 0); idle0(); idle0();
        send0(1, 1, 0, 0, 0, 0); send0(1, 0, 0, 0, 0, 0);
        send0(1, 1, 0, 0, 0, 1); idle0();
        chk("s3_count", cnt0, 1);

        // Pattern reload clears history
        clr0();
        load0(4'b1011);
        bits0(16'b101, 16'b000, 3);
        load0(4'b0110);
        bits0(16'b1100110, 16'b0000001, 7);
        idle0();
        chk("s5_count", cnt0, 1);

        // Saturation on the 2-bit counter, then clear beating a same-cycle match
        ov1 = 1'b1;
        send1(0, 0, 1, 2'b11, 0, 0);
        for (int k = 0; k < 6; k++) send1(1, 1, 0, 2'b00, 0, k != 0);
        send1(0, 0, 0, 2'b00, 0, 0);
        chk("s4_sat", cnt1, 3);
        send1(1, 1, 0, 2'b00, 1, 1);
        send1(0, 0, 0, 2'b00, 0, 0);
        chk("s4_clr", cnt1, 0);

        // Reset mid-stream disarms; unreloaded stream never matches
        load0(4'b1011);
        bits0(16'b101, 16'b000, 3);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("s6_y", y0, 0);
        chk("s6_armed", arm0, 0);
        chk("s6_count", cnt0, 0);
        @(posedge clk); #1 reset = 1'b0;
        pe0 = 0; pe1 = 0;
        bits0(16'b1011, 16'b0000, 4);
        idle0();
        chk("s6_no_match", cnt0, 0);

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 399) == 0);
            x0 = $urandom_range(0, 1); xv0 = ($urandom_range(0, 3) != 0);
            pl0 = ($urandom_range(0, 39) == 0); pin0 = 4'($urandom);
            cc0 = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) ov0 = ~ov0;
            x1 = ($urandom_range(0, 2) != 0); xv1 = ($urandom_range(0, 3) != 0);
            pl1 = ($urandom_range(0, 39) == 0); pin1 = 2'($urandom);
            cc1 = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) ov1 = ~ov1;
        end
        @(posedge clk); #1;
        reset = 1'b0; xv0 = 0; xv1 = 0; pl0 = 0; pl1 = 0; cc0 = 0; cc1 = 0;
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
